control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the datapath's control inputs (PCout, MARin, Zin, Read, Rin/Rout...).
//  Steps fetch T0-T2 and execute T3-T6 for register-class instructions, one step per clock.
//  Sits upstream of the datapath and reads the IR contents back from it.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles T1 may wait for Mem_ready before Bus_error
//  OPW           5   width of opcode / ALU operation field
// PORTS
//  Clock      in   1   system clock, rising edge
//  Reset_n    in   1   asynchronous, active-low reset
//  IR         in   32  datapath IR; opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//  Mem_ready  in   1   memory has valid data on Mdatain this cycle
//  Stop       in   1   request halt at next instruction boundary
//  PCout,MARin,IncPC,Zin,PCin,Read,MDRin,MDRout,IRin,Yin  out 1 each  datapath strobes
//  Zlowout,Zhighout,LOin,HIin  out 1 each  Z/LO/HI transfer strobes
//  Gra,Grb,Grc,Rin,Rout        out 1 each  register-select and transfer strobes to the select/encode logic
//  operation  out  OPW  ALU function; equals IR opcode in the ALU step, else 0
//  Run        out  1   high while sequencing; low in IDLE and HALT
//  Illegal    out  1   one-cycle pulse on an undecodable opcode
//  Bus_error  out  1   sticky; set on memory timeout
// BEHAVIOUR
//  - States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State register only; all outputs decode from state+IR (Moore).
//  - Reset_n low: async to IDLE. All outputs 0 immediately, wait counter 0, Bus_error 0.
//    Reset mid-instruction abandons it with no further strobes.
//  - IDLE -> T0 on the first rising edge with Reset_n high.
//  - T0: PCout, MARin, IncPC, Zin.
//  - T1: Zlowout, PCin, Read, MDRin.
//    - Holds while Mem_ready=0; the wait counter increments each held cycle.
//    - Zlowout/PCin assert only in the first T1 cycle, so PC is loaded once.
//    - Read/MDRin stay high for every T1 cycle.
//    - Mem_ready=1 -> T2, counter cleared.
//    - Counter reaching MEM_WAIT_MAX with Mem_ready=0 -> HALT and Bus_error=1.
//  - T2: MDRout, IRin. IR is valid from T3 onward; decode uses the IR value in T3.
//  - Class R3: opcode 00000-01010 (add,sub,and,or,shr,shra,shl,ror,rol,...).
//    - T3: Grb, Rout, Yin.
//    - T4: Grc, Rout, Zin, operation=opcode.
//    - T5: Zlowout, Gra, Rin.
//    - Then boundary.
//  - Class MD: opcode 01111 mul, 10000 div.
//    - T3: Gra, Rout, Yin.
//    - T4: Grb, Rout, Zin, operation=opcode.
//    - T5: Zlowout, LOin.
//    - T6: Zhighout, HIin.
//    - Then boundary.
//  - Class R2: opcode 10001 neg, 10010 not.
//    - T3: Grb, Rout, Zin, operation=opcode.
//    - T4: Zlowout, Gra, Rin.
//    - Then boundary.
//  - Other opcodes: Illegal pulses in T3, no register writes; T3 is the boundary.
//  - Boundary: if Stop=1 sampled on the boundary edge -> HALT, else -> T0. Stop is ignored mid-instruction.
//  - HALT: all strobes 0, Run=0, Bus_error held. Exit only via Reset_n.
//  - Run=1 in T0-T6.
//  - At most one of Rout/MDRout/PCout/Zlowout/Zhighout is high in any cycle.
//  - Latency with Mem_ready already high in T1: R3=6, R2=5, MD=7 clocks per instruction.
// TESTING
//  - Reset: hold Reset_n=0 in T4 -> all outputs 0 at once; release -> T0 on next edge with PCout=MARin=1.
//  - SHR R4,R5,R7, IR=0x2A2B8000, Mem_ready=1:
//    - T3: Grb+Rout+Yin; T4: Grc+Rout+Zin with operation=5'b00101; T5: Gra+Rin+Zlowout.
//    - Next instruction starts in T0 six clocks after the previous T0.
//  - Mul, IR opcode 01111: T5 asserts LOin with Zlowout, T6 asserts HIin with Zhighout; 7-clock instruction.
//  - Mem_ready low 3 cycles in T1:
//    - T1 lasts 4 cycles; PCin high only in the first; Read high all 4.
//    - Mem_ready never rises -> Bus_error=1 and HALT after 15 cycles.
//  - Opcode 11111: Illegal high for exactly one clock in T3; Rin never asserts; next state T0.
//  - Stop=1 raised during T4 of an add: T5 completes, then HALT with Run=0; Reset_n pulse restarts at T0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for a simple register-class datapath. It steps an
//   instruction fetch (T0-T2) followed by a class-dependent execute (T3-T6),
//   one step per clock, and drives the datapath transfer strobes as a Moore
//   decode of the current state and the IR opcode.
//
//   State | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | out of reset, nothing driven; leaves on the first clock edge
//   T0    | PC -> MAR, PC incremented into Z
//   T1    | Z -> PC (first cycle only), memory read, waits for Mem_ready
//   T2    | MDR -> IR
//   T3    | first execute step; opcode decoded from the live IR here
//   T4    | second execute step
//   T5    | third execute step
//   T6    | fourth execute step (mul/div only)
//   HALT  | stopped, only a reset leaves this state
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_ir           datapath IR; opcode in [31:27]
//   i_mem_ready    memory data valid this cycle
//   i_stop         halt request, honoured only at an instruction boundary
//   o_pc_out .. o_y_in           datapath strobes
//   o_zlow_out .. o_hi_in        Z/LO/HI transfer strobes
//   o_gra .. o_r_out             register select / transfer strobes
//   o_operation    ALU function (opcode during the ALU step, else 0)
//   o_run          high while sequencing (T0-T6)
//   o_illegal      pulse in T3 for an undecodable opcode
//   o_bus_error    sticky memory-timeout flag
module control_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int OPW          = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [31:0]    i_ir,
  input  logic           i_mem_ready,
  input  logic           i_stop,
  output logic           o_pc_out,
  output logic           o_mar_in,
  output logic           o_inc_pc,
  output logic           o_z_in,
  output logic           o_pc_in,
  output logic           o_read,
  output logic           o_mdr_in,
  output logic           o_mdr_out,
  output logic           o_ir_in,
  output logic           o_y_in,
  output logic           o_zlow_out,
  output logic           o_zhigh_out,
  output logic           o_lo_in,
  output logic           o_hi_in,
  output logic           o_gra,
  output logic           o_grb,
  output logic           o_grc,
  output logic           o_r_in,
  output logic           o_r_out,
  output logic [OPW-1:0] o_operation,
  output logic           o_run,
  output logic           o_illegal,
  output logic           o_bus_error
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_wait, w_wait_next;
  logic           r_bus_error, w_bus_error_next;
  logic [OPW-1:0] r_op;
  logic [OPW-1:0] w_op;
  logic           w_is_r3, w_is_md, w_is_r2;
  logic           w_boundary;
  state_t         w_exit;
  logic           w_unused_ir;

  assign w_unused_ir = ^i_ir[31-OPW:0];

  // The opcode is taken straight from IR in T3 and held in r_op for the rest
  // of the instruction, so a changing IR after T3 cannot disturb execution.
  assign w_op    = (r_state == S_T3) ? i_ir[31 -: OPW] : r_op;
  assign w_is_r3 = (w_op <= OPW'(10));
  assign w_is_md = (w_op == OPW'(15)) || (w_op == OPW'(16));
  assign w_is_r2 = (w_op == OPW'(17)) || (w_op == OPW'(18));

  // Last execute step of the current instruction; illegal opcodes end in T3.
  assign w_boundary = ((r_state == S_T3) && !(w_is_r3 || w_is_md || w_is_r2)) ||
                      ((r_state == S_T4) && w_is_r2) ||
                      ((r_state == S_T5) && w_is_r3) ||
                      ((r_state == S_T6) && w_is_md);
  assign w_exit     = i_stop ? S_HALT : S_T0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_bus_error <= 1'b0;
      r_op        <= '0;
    end else begin
      r_state     <= w_next;
      r_wait      <= w_wait_next;
      r_bus_error <= w_bus_error_next;
      if (r_state == S_T3) r_op <= i_ir[31 -: OPW];
    end
  end

  always_comb begin
    w_next           = r_state;
    w_wait_next      = r_wait;
    w_bus_error_next = r_bus_error;
    case (r_state)
      S_IDLE: w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1: begin
        if (i_mem_ready) begin
          w_next      = S_T2;
          w_wait_next = '0;
        end else if (r_wait == CW'(MEM_WAIT_MAX - 1)) begin
          // This held cycle brings the count to MEM_WAIT_MAX: give up.
          w_next           = S_HALT;
          w_wait_next      = '0;
          w_bus_error_next = 1'b1;
        end else begin
          w_wait_next = r_wait + CW'(1);
        end
      end
      S_T2:   w_next = S_T3;
      S_T3:   w_next = w_boundary ? w_exit : S_T4;
      S_T4:   w_next = w_boundary ? w_exit : S_T5;
      S_T5:   w_next = w_boundary ? w_exit : S_T6;
      S_T6:   w_next = w_exit;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_run       = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_bus_error = r_bus_error;

  always_comb begin
    o_pc_out    = 1'b0;
    o_mar_in    = 1'b0;
    o_inc_pc    = 1'b0;
    o_z_in      = 1'b0;
    o_pc_in     = 1'b0;
    o_read      = 1'b0;
    o_mdr_in    = 1'b0;
    o_mdr_out   = 1'b0;
    o_ir_in     = 1'b0;
    o_y_in      = 1'b0;
    o_zlow_out  = 1'b0;
    o_zhigh_out = 1'b0;
    o_lo_in     = 1'b0;
    o_hi_in     = 1'b0;
    o_gra       = 1'b0;
    o_grb       = 1'b0;
    o_grc       = 1'b0;
    o_r_in      = 1'b0;
    o_r_out     = 1'b0;
    o_operation = '0;
    o_illegal   = 1'b0;
    case (r_state)
      S_T0: begin
        o_pc_out = 1'b1;
        o_mar_in = 1'b1;
        o_inc_pc = 1'b1;
        o_z_in   = 1'b1;
      end
      S_T1: begin
        o_read   = 1'b1;
        o_mdr_in = 1'b1;
        // PC is reloaded only once, however long memory keeps us waiting.
        if (r_wait == '0) begin
          o_zlow_out = 1'b1;
          o_pc_in    = 1'b1;
        end
      end
      S_T2: begin
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
      end
      S_T3: begin
        if (w_is_r3) begin
          o_grb   = 1'b1;
          o_r_out = 1'b1;
          o_y_in  = 1'b1;
        end else if (w_is_md) begin
          o_gra   = 1'b1;
          o_r_out = 1'b1;
          o_y_in  = 1'b1;
        end else if (w_is_r2) begin
          o_grb       = 1'b1;
          o_r_out     = 1'b1;
          o_z_in      = 1'b1;
          o_operation = w_op;
        end else begin
          o_illegal = 1'b1;
        end
      end
      S_T4: begin
        if (w_is_r3) begin
          o_grc       = 1'b1;
          o_r_out     = 1'b1;
          o_z_in      = 1'b1;
          o_operation = w_op;
        end else if (w_is_md) begin
          o_grb       = 1'b1;
          o_r_out     = 1'b1;
          o_z_in      = 1'b1;
          o_operation = w_op;
        end else if (w_is_r2) begin
          o_zlow_out = 1'b1;
          o_gra      = 1'b1;
          o_r_in     = 1'b1;
        end
      end
      S_T5: begin
        if (w_is_r3) begin
          o_zlow_out = 1'b1;
          o_gra      = 1'b1;
          o_r_in     = 1'b1;
        end else if (w_is_md) begin
          o_zlow_out = 1'b1;
          o_lo_in    = 1'b1;
        end
      end
      S_T6: begin
        if (w_is_md) begin
          o_zhigh_out = 1'b1;
          o_hi_in     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a step/phase model of the instruction flow is
// checked against the DUT every cycle, plus directed literal expectations.
module tb_control_sequencer;

  localparam int MEM_WAIT_MAX = 15;

  // Bit positions of the packed output vector.
  localparam int PCOUT = 26, MARIN = 25, INCPC = 24, ZIN = 23, PCIN = 22;
  localparam int READ = 21, MDRIN = 20, MDROUT = 19, IRIN = 18, YIN = 17;
  localparam int ZLO = 16, ZHI = 15, LOIN = 14, HIIN = 13, GRA = 12;
  localparam int GRB = 11, GRC = 10, RIN = 9, ROUT = 8, RUN = 2, ILL = 1, BERR = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  localparam int C_R3 = 0, C_MD = 1, C_R2 = 2, C_ILL = 3;

  localparam logic [31:0] IR_SHR = 32'h2A2B_8000;
  localparam logic [31:0] IR_ADD = 32'h0A2B_8000;
  localparam logic [31:0] IR_MUL = 32'h7A2B_8000;
  localparam logic [31:0] IR_NEG = 32'h8A2B_8000;
  localparam logic [31:0] IR_BAD = 32'hF800_0000;

  logic        clk, rst_n, mem_ready, stop;
  logic [31:0] ir;
  logic pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
  logic zlow_out, zhigh_out, lo_in, hi_in, gra, grb, grc, r_in, r_out;
  logic [4:0] operation;
  logic run, illegal, bus_error;
  logic [26:0] dut_vec;

  control_sequencer #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .OPW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ir(ir), .i_mem_ready(mem_ready), .i_stop(stop),
    .o_pc_out(pc_out), .o_mar_in(mar_in), .o_inc_pc(inc_pc), .o_z_in(z_in),
    .o_pc_in(pc_in), .o_read(read), .o_mdr_in(mdr_in), .o_mdr_out(mdr_out),
    .o_ir_in(ir_in), .o_y_in(y_in), .o_zlow_out(zlow_out), .o_zhigh_out(zhigh_out),
    .o_lo_in(lo_in), .o_hi_in(hi_in), .o_gra(gra), .o_grb(grb), .o_grc(grc),
    .o_r_in(r_in), .o_r_out(r_out), .o_operation(operation), .o_run(run),
    .o_illegal(illegal), .o_bus_error(bus_error)
  );

  assign dut_vec = {pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in, mdr_out,
                    ir_in, y_in, zlow_out, zhigh_out, lo_in, hi_in, gra, grb, grc,
                    r_in, r_out, operation, run, illegal, bus_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model: mode, fetch/execute step number, memory wait count, opcode.
  int         m_mode, m_step, m_wait;
  logic [4:0] m_op;
  bit         m_bus;
  int         n_mode, n_step, n_wait;
  logic [4:0] n_op;
  bit         n_bus;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int op_class(input logic [4:0] op);
    if (op <= 5'd10) return C_R3;
    if (op == 5'd15 || op == 5'd16) return C_MD;
    if (op == 5'd17 || op == 5'd18) return C_R2;
    return C_ILL;
  endfunction

  // Step index at which each class finishes (fetch is steps 0-2).
  function automatic int last_step(input int c);
    case (c)
      C_R3: return 5;
      C_MD: return 6;
      C_R2: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [26:0] model_out();
    logic [26:0] e;
    logic [4:0]  op;
    e = '0;
    e[BERR] = m_bus;
    if (m_mode != M_RUN) return e;
    e[RUN] = 1'b1;
    op = (m_step == 3) ? ir[31:27] : m_op;
    case (m_step)
      0: begin e[PCOUT] = 1; e[MARIN] = 1; e[INCPC] = 1; e[ZIN] = 1; end
      1: begin
        e[READ] = 1; e[MDRIN] = 1;
        if (m_wait == 0) begin e[ZLO] = 1; e[PCIN] = 1; end
      end
      2: begin e[MDROUT] = 1; e[IRIN] = 1; end
      default: begin
        case (op_class(op))
          C_R3: case (m_step)
            3: begin e[GRB] = 1; e[ROUT] = 1; e[YIN] = 1; end
            4: begin e[GRC] = 1; e[ROUT] = 1; e[ZIN] = 1; e[7:3] = op; end
            5: begin e[ZLO] = 1; e[GRA] = 1; e[RIN] = 1; end
            default: ;
          endcase
          C_MD: case (m_step)
            3: begin e[GRA] = 1; e[ROUT] = 1; e[YIN] = 1; end
            4: begin e[GRB] = 1; e[ROUT] = 1; e[ZIN] = 1; e[7:3] = op; end
            5: begin e[ZLO] = 1; e[LOIN] = 1; end
            6: begin e[ZHI] = 1; e[HIIN] = 1; end
            default: ;
          endcase
          C_R2: case (m_step)
            3: begin e[GRB] = 1; e[ROUT] = 1; e[ZIN] = 1; e[7:3] = op; end
            4: begin e[ZLO] = 1; e[GRA] = 1; e[RIN] = 1; end
            default: ;
          endcase
          default: if (m_step == 3) e[ILL] = 1;
        endcase
      end
    endcase
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_step = 0; m_wait = 0; m_op = '0; m_bus = 0;
  endtask

  // Computes the model state after the coming clock edge from current inputs.
  task automatic model_next();
    logic [4:0] op;
    n_mode = m_mode; n_step = m_step; n_wait = m_wait; n_op = m_op; n_bus = m_bus;
    if (!rst_n) return;
    if (m_mode == M_IDLE) begin
      n_mode = M_RUN; n_step = 0;
    end else if (m_mode == M_RUN) begin
      if (m_step == 0) n_step = 1;
      else if (m_step == 1) begin
        if (mem_ready) begin n_step = 2; n_wait = 0; end
        else if (m_wait + 1 == MEM_WAIT_MAX) begin n_mode = M_HALT; n_bus = 1; n_wait = 0; end
        else n_wait = m_wait + 1;
      end else if (m_step == 2) n_step = 3;
      else begin
        op = (m_step == 3) ? ir[31:27] : m_op;
        if (m_step == 3) n_op = op;
        if (m_step == last_step(op_class(op))) begin
          if (stop) n_mode = M_HALT;
          else n_step = 0;
        end else n_step = m_step + 1;
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, advance model at the rising edge.
  task automatic cyc(input logic [31:0] ir_v, input logic rdy, input logic stp, input logic rst_v);
    @(negedge clk);
    #2;
    ir = ir_v; mem_ready = rdy; stop = stp;
    if (!rst_v) begin
      rst_n = 1'b0;
      model_reset();
    end else rst_n = 1'b1;
    model_next();
    @(posedge clk);
    #1;
    m_mode = n_mode; m_step = n_step; m_wait = n_wait; m_op = n_op; m_bus = n_bus;
  endtask

  task automatic assert_reset_check(input string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk(name, dut_vec, 27'd0);
  endtask

  logic [26:0] snap [1:10];

  // Runs one instruction from T0 with memory always ready; returns the clock
  // count until PCout rises again (0 if it never does within 10 clocks).
  task automatic run_instr(input logic [31:0] ir_v, output int len);
    len = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(ir_v, 1'b1, 1'b0, 1'b1);
      snap[i] = dut_vec;
      if (pc_out && len == 0) begin
        len = i;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle_outputs", dut_vec, model_out());
      chk("bus_drivers_onehot", ($countones({r_out, mdr_out, pc_out, zlow_out, zhigh_out}) <= 1), 1);
    end
  end

  initial begin
    int len, cnt, hc;
    logic [31:0] rnd, rir;
    logic [4:0]  rop;
    logic        rv;

    rst_n = 1'b1; ir = '0; mem_ready = 1'b0; stop = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs_zero", dut_vec, 27'd0);
    cmp_en = 1'b1;

    cyc(IR_SHR, 1, 0, 0);
    cyc(IR_SHR, 1, 0, 1);
    chk("release_t0_pcout_marin", {pc_out, mar_in, run}, 3'b111);

    run_instr(IR_SHR, len);
    chk("shr_latency", len, 6);
    chk("shr_t3", {snap[3][GRB], snap[3][ROUT], snap[3][YIN], snap[3][ZIN]}, 4'b1110);
    chk("shr_t4", {snap[4][GRC], snap[4][ROUT], snap[4][ZIN], snap[4][7:3]}, {3'b111, 5'b00101});
    chk("shr_t5", {snap[5][GRA], snap[5][RIN], snap[5][ZLO]}, 3'b111);

    run_instr(IR_MUL, len);
    chk("mul_latency", len, 7);
    chk("mul_t4_op", snap[4][7:3], 5'b01111);
    chk("mul_t5", {snap[5][LOIN], snap[5][ZLO], snap[5][RIN]}, 3'b110);
    chk("mul_t6", {snap[6][HIIN], snap[6][ZHI]}, 2'b11);

    run_instr(IR_NEG, len);
    chk("neg_latency", len, 5);
    chk("neg_t3", {snap[3][ZIN], snap[3][YIN], snap[3][7:3]}, {2'b10, 5'b10001});

    run_instr(IR_BAD, len);
    chk("illegal_latency", len, 4);
    cnt = 0;
    for (int i = 1; i <= 4; i++) cnt += int'(snap[i][ILL]);
    chk("illegal_one_pulse", cnt, 1);
    chk("illegal_t3", {snap[3][ILL], snap[3][RIN]}, 2'b10);

    cyc(IR_ADD, 0, 0, 1);
    chk("wait_first_t1", {pc_in, zlow_out, read}, 3'b111);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(IR_ADD, 0, 0, 1);
      if (!pc_in && read && mdr_in) cnt++;
    end
    chk("wait_held_t1", cnt, 3);
    cyc(IR_ADD, 1, 0, 1);
    chk("wait_t2", {mdr_out, ir_in, read}, 3'b110);
    repeat (4) cyc(IR_ADD, 1, 0, 1);
    chk("wait_back_t0", pc_out, 1'b1);

    repeat (4) cyc(IR_ADD, 1, 0, 1);
    cyc(IR_ADD, 1, 1, 1);
    chk("stop_t5_completes", {run, gra, r_in, zlow_out}, 4'b1111);
    cyc(IR_ADD, 1, 1, 1);
    chk("stop_halted", dut_vec, 27'd0);
    repeat (3) cyc(IR_ADD, 1, 0, 1);
    chk("halt_stays", run, 1'b0);
    cyc(IR_ADD, 1, 0, 0);
    cyc(IR_ADD, 1, 0, 1);
    chk("restart_after_halt", {pc_out, mar_in}, 2'b11);

    repeat (4) cyc(IR_ADD, 1, 0, 1);
    chk("pre_reset_in_t4", {grc, z_in}, 2'b11);
    assert_reset_check("reset_in_t4_zero");
    cyc(IR_ADD, 1, 0, 0);
    cyc(IR_ADD, 1, 0, 1);
    chk("reset_release_t0", {pc_out, mar_in}, 2'b11);

    cyc(IR_ADD, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(IR_ADD, 0, 0, 1);
      if (read && run && !bus_error) cnt++;
    end
    chk("timeout_t1_held", cnt, 14);
    cyc(IR_ADD, 0, 0, 1);
    chk("timeout_halt", {run, bus_error, read}, 3'b010);
    cyc(IR_ADD, 1, 0, 1);
    chk("bus_error_sticky", bus_error, 1'b1);
    assert_reset_check("reset_clears_bus_error");
    cyc(IR_ADD, 1, 0, 1);

    rir = IR_ADD;
    hc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_mode == M_HALT) hc++;
      else hc = 0;
      rv = !(hc > 3 || $urandom_range(0, 299) == 0);
      if (!(m_mode == M_RUN && m_step == 3)) begin
        rnd = $urandom();
        case ($urandom_range(0, 9))
          0, 1, 2, 3: rop = 5'($urandom_range(0, 10));
          4, 5:       rop = 5'($urandom_range(15, 16));
          6, 7:       rop = 5'($urandom_range(17, 18));
          default:    rop = 5'($urandom_range(0, 31));
        endcase
        rir = {rop, rnd[26:0]};
      end
      cyc(rir, $urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, rv);
    end

    @(negedge clk);
    #2;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
